// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two requesters.
// Optional misalignment check enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [1:0]            m0_maskmode,
  input  logic                  m0_sext,
  input  logic [DATA_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [1:0]            m1_maskmode,
  input  logic                  m1_sext,
  input  logic [DATA_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_port;
  logic                  r_we;
  logic [1:0]            r_mask;
  logic                  r_sext;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rsp_err;

  logic                  w_accept;
  logic                  w_sel;
  logic                  w_sel_we;
  logic [1:0]            w_sel_mask;
  logic                  w_sel_sext;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // On a tie the port that did not win last time is served.
  always_comb begin
    w_accept    = (m0_req | m1_req) & (r_state != ACCESS) & ~reset;
    w_sel       = (m0_req & m1_req) ? ~r_last_grant : m1_req;
    w_sel_we    = w_sel ? m1_we       : m0_we;
    w_sel_mask  = w_sel ? m1_maskmode : m0_maskmode;
    w_sel_sext  = w_sel ? m1_sext     : m0_sext;
    w_sel_addr  = w_sel ? m1_addr     : m0_addr;
    w_sel_wdata = w_sel ? m1_wdata    : m0_wdata;
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  always_comb begin
    case (w_sel_mask)
      2'b00:   w_sel_err = 1'b0;
      2'b01:   w_sel_err = w_sel_addr[0];
      default: w_sel_err = |w_sel_addr[1:0];
    endcase
  end
`else
  assign w_sel_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_mask       <= '0;
      r_sext       <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_port       <= w_sel;
            r_last_grant <= w_sel;
            r_we         <= w_sel_we;
            r_mask       <= w_sel_mask;
            r_sext       <= w_sel_sext;
            r_err        <= w_sel_err;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_state      <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_rdata   <= (~r_we & ~r_err) ? mem_read_data : '0;
          r_rsp_err <= r_err;
          r_state   <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_gnt         = w_accept & ~w_sel;
  assign m1_gnt         = w_accept & w_sel;
  assign m0_rvalid      = (r_state == RESP) & ~r_port;
  assign m1_rvalid      = (r_state == RESP) & r_port;
  assign rsp_rdata      = r_rdata;
  assign rsp_err        = r_rsp_err;
  // Write gated by reset so a reset during ACCESS suppresses the negedge write.
  assign mem_write      = (r_state == ACCESS) & r_we & ~reset & ~r_err;
  assign mem_read       = (r_state == ACCESS) & ~r_we;
  assign mem_maskmode   = r_mask;
  assign mem_sext       = r_sext;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: data memory behavioural model plus a
// byte-level reference memory and transaction-level expectations.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_sext, m1_req, m1_we, m1_sext;
  logic [1:0]  m0_maskmode, m1_maskmode;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rsp_err;
  logic        mem_write, mem_read, mem_sext;
  logic [1:0]  mem_maskmode;
  logic [31:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] env_mem [0:63];
  logic [7:0]  ref_mem [0:255];

  dmem_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_maskmode(m0_maskmode), .m0_sext(m0_sext),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_maskmode(m1_maskmode), .m1_sext(m1_sext),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_maskmode(mem_maskmode),
    .mem_sext(mem_sext), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Data memory model: negedge write, combinational read; sext=0 sign-extends.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lo,
                                        input logic [1:0] mm, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (mm)
      2'b00:   r[{lo, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{lo[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(negedge clk)
    if (mem_write)
      env_mem[mem_address[7:2]] <= merge(env_mem[mem_address[7:2]], mem_address[1:0],
                                         mem_maskmode, mem_write_data);

  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = env_mem[mem_address[7:2]];
    b = w[{mem_address[1:0], 3'b000} +: 8];
    h = w[{mem_address[1], 4'b0000} +: 16];
    case (mem_maskmode)
      2'b00:   mem_read_data = mem_sext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   mem_read_data = mem_sext ? {16'h0, h} : {{16{h[15]}}, h};
      default: mem_read_data = w;
    endcase
  end

  // Reference model over a byte array.
  function automatic logic exp_err(input logic [1:0] mm, input logic [31:0] a);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (mm == 2'b00) return 1'b0;
    if (mm == 2'b01) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] mm, input logic sx,
                                           input logic [31:0] a);
    logic [7:0]  i;
    logic [15:0] h;
    i = a[7:0];
    case (mm)
      2'b00: return sx ? {24'h0, ref_mem[i]} : {{24{ref_mem[i][7]}}, ref_mem[i]};
      2'b01: begin
        i[0] = 1'b0;
        h = {ref_mem[i + 8'd1], ref_mem[i]};
        return sx ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: begin
        i[1:0] = 2'b00;
        return {ref_mem[i + 8'd3], ref_mem[i + 8'd2], ref_mem[i + 8'd1], ref_mem[i]};
      end
    endcase
  endfunction

  task automatic ref_access(input logic we, input logic [1:0] mm, input logic sx,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] e_rd, output logic e_err);
    logic [7:0] i;
    e_err = exp_err(mm, a);
    e_rd  = (we || e_err) ? 32'h0 : ref_load(mm, sx, a);
    if (we && !e_err) begin
      i = a[7:0];
      case (mm)
        2'b00: ref_mem[i] = d[7:0];
        2'b01: begin
          i[0] = 1'b0;
          ref_mem[i] = d[7:0]; ref_mem[i + 8'd1] = d[15:8];
        end
        default: begin
          i[1:0] = 2'b00;
          ref_mem[i] = d[7:0];          ref_mem[i + 8'd1] = d[15:8];
          ref_mem[i + 8'd2] = d[23:16]; ref_mem[i + 8'd3] = d[31:24];
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rq, input logic we, input logic [1:0] mm,
                          input logic sx, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_req = rq; m0_we = we; m0_maskmode = mm; m0_sext = sx; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = rq; m1_we = we; m1_maskmode = mm; m1_sext = sx; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Runs one access on port p and reports what was observed (no checking here).
  task automatic issue(input int p, input logic we, input logic [1:0] mm, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lg, output int lv, output logic ws,
                       output logic [31:0] rd, output logic er, output logic stray);
    int t0;
    lg = -1; lv = -1; ws = 1'b0; rd = 32'hx; er = 1'bx; stray = 1'b0;
    step();
    t0 = cyc;
    set_port(p, 1'b1, we, mm, sx, a, d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((p == 0) ? m0_gnt : m1_gnt) begin
        lg = cyc - t0;
        break;
      end
      step();
    end
    step();
    set_port(p, 1'b0, we, mm, sx, a, d);
    if (lg < 0) return;
    @(negedge clk);
    ws = mem_write;
    stray = m0_rvalid | m1_rvalid;
    for (int k = 2; k < 6; k++) begin
      step();
      @(negedge clk);
      stray = stray | ((p == 0) ? m1_rvalid : m0_rvalid);
      if ((p == 0) ? m0_rvalid : m1_rvalid) begin
        lv = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    step();
    set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rsp_err, mem_write, mem_read, mem_sext,
         mem_maskmode} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
               rsp_err, mem_write, mem_read, mem_sext, mem_maskmode});
    end
    checks++;
    if ({rsp_rdata, mem_address, mem_write_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rsp_rdata,
               mem_address, mem_write_data);
    end
  endtask

  task automatic test_store_load();
    int lg, lv; logic ws, er, st; logic [31:0] rd, e_rd; logic e_err;
    ref_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, e_rd, e_err);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lg, lv, ws, rd, er, st);
    checks++;
    if (lg !== 0) begin errors++; $display("FAIL store_gnt_latency got %0d want 0", lg); end
    checks++;
    if (ws !== 1'b1) begin errors++; $display("FAIL store_mem_write got %b want 1", ws); end
    checks++;
    if (lv !== 2) begin errors++; $display("FAIL store_rvalid_latency got %0d want 2", lv); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got %h want 0", rd); end
    ref_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e_rd, e_err);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lg, lv, ws, rd, er, st);
    checks++;
    if (rd !== 32'hDEADBEEF || lv !== 2 || ws !== 1'b0) begin
      errors++;
      $display("FAIL load_word got rd=%h lv=%0d ws=%b want DEADBEEF/2/0", rd, lv, ws);
    end
    step(); step();
    @(negedge clk);
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rdata_hold got %h want DEADBEEF", rsp_rdata);
    end
  endtask

  task automatic test_fairness();
    int exp_port [0:15];
    int last, ngnt, gp, w;
    logic [31:0] a0, a1, e;
    logic [1:0]  erv;
    last = 1; ngnt = 0; a0 = 32'h10; a1 = 32'h14;
    for (int i = 0; i < 16; i++) exp_port[i] = -1;
    apply_reset();
    set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, a0, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, a1, 32'h0);
    for (int r = 0; r < 9; r++) begin
      @(negedge clk);
      erv = (exp_port[r] == 0) ? 2'b01 : (exp_port[r] == 1) ? 2'b10 : 2'b00;
      checks++;
      if ({m1_rvalid, m0_rvalid} !== erv) begin
        errors++;
        $display("FAIL fair_rvalid cycle %0d got %b want %b", r, {m1_rvalid, m0_rvalid}, erv);
      end
      if (exp_port[r] >= 0) begin
        e = ref_load(2'b10, 1'b0, (exp_port[r] == 0) ? a0 : a1);
        checks++;
        if (rsp_rdata !== e) begin
          errors++; $display("FAIL fair_rdata cycle %0d got %h want %h", r, rsp_rdata, e);
        end
      end
      if (m0_gnt || m1_gnt) begin
        w = 1 - last;
        gp = m1_gnt ? 1 : 0;
        checks++;
        if ((m0_gnt && m1_gnt) || gp != w) begin
          errors++;
          $display("FAIL fair_order grant %0d got %b%b want port %0d", ngnt, m1_gnt, m0_gnt, w);
        end
        exp_port[r + 2] = w;
        last = w;
        ngnt++;
      end
      step();
    end
    set_port(0, 1'b0, 1'b0, 2'b10, 1'b0, a0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b10, 1'b0, a1, 32'h0);
    step(); step();
    checks++;
    if (ngnt != 5) begin errors++; $display("FAIL fair_count got %0d want 5", ngnt); end
  endtask

  task automatic test_back_to_back();
    logic eg, ev;
    step();
    set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    for (int r = 0; r < 9; r++) begin
      @(negedge clk);
      eg = (r % 2 == 0);
      ev = (r >= 2) && (r % 2 == 0);
      checks++;
      if ({m1_gnt, m1_rvalid, m0_gnt, m0_rvalid} !== {eg, ev, 2'b00}) begin
        errors++;
        $display("FAIL b2b cycle %0d got gnt1=%b rv1=%b gnt0=%b rv0=%b want %b %b 0 0",
                 r, m1_gnt, m1_rvalid, m0_gnt, m0_rvalid, eg, ev);
      end
      step();
    end
    set_port(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step(); step();
  endtask

  task automatic test_reset_mid_access();
    int lg, lv; logic ws, er, st, sawrv; logic [31:0] rd, e_rd; logic e_err;
    ref_access(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, e_rd, e_err);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, lg, lv, ws, rd, er, st);
    step();
    set_port(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt got %b want 1", m0_gnt); end
    step();
    set_port(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL rst_mid_write got %b want 0", mem_write);
    end
    step();
    reset = 1'b0;
    sawrv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sawrv = sawrv | m0_rvalid | m1_rvalid;
      step();
    end
    checks++;
    if (sawrv !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid got %b want 0", sawrv); end
    checks++;
    if (env_mem[8] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rst_mid_mem got %h want A5A5A5A5", env_mem[8]);
    end
    ref_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e_rd, e_err);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lg, lv, ws, rd, er, st);
    checks++;
    if (lg !== 0 || rd !== e_rd) begin
      errors++; $display("FAIL rst_mid_reload got lg=%0d rd=%h want 0/%h", lg, rd, e_rd);
    end
  endtask

  task automatic test_byte_sext();
    int lg, lv; logic ws, er, st; logic [31:0] rd, e_rd; logic e_err;
    ref_access(1'b1, 2'b00, 1'b0, 32'h30, 32'h000000F0, e_rd, e_err);
    issue(1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h000000F0, lg, lv, ws, rd, er, st);
    issue(1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, lg, lv, ws, rd, er, st);
    checks++;
    if (rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL byte_sext0 got %h want FFFFFFF0", rd); end
    issue(0, 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, lg, lv, ws, rd, er, st);
    checks++;
    if (rd !== 32'h000000F0) begin errors++; $display("FAIL byte_sext1 got %h want 000000F0", rd); end
  endtask

  task automatic test_align();
    int lg, lv; logic ws, er, st; logic [31:0] rd, e_rd; logic e_err, want_err;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    ref_access(1'b1, 2'b10, 1'b0, 32'h42, 32'hCAFEF00D, e_rd, e_err);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h42, 32'hCAFEF00D, lg, lv, ws, rd, er, st);
    checks++;
    if (er !== want_err || ws !== ~want_err) begin
      errors++;
      $display("FAIL align_store got err=%b write=%b want %b/%b", er, ws, want_err, ~want_err);
    end
    ref_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, e_rd, e_err);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lg, lv, ws, rd, er, st);
    checks++;
    if (rd !== (want_err ? 32'h0 : 32'hCAFEF00D) || rd !== e_rd) begin
      errors++; $display("FAIL align_reload got %h want %h", rd, e_rd);
    end
  endtask

  task automatic test_random();
    int lg, lv, p; logic ws, er, st, we, sx; logic [1:0] mm;
    logic [31:0] a, d, rd, e_rd; logic e_err;
    for (int n = 0; n < 40; n++) begin
      p  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      mm = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 255);
      d  = $urandom;
      ref_access(we, mm, sx, a, d, e_rd, e_err);
      issue(p, we, mm, sx, a, d, lg, lv, ws, rd, er, st);
      checks++;
      if (lg !== 0 || lv !== 2 || st !== 1'b0) begin
        errors++;
        $display("FAIL rand_timing #%0d got lg=%0d lv=%0d stray=%b want 0/2/0", n, lg, lv, st);
      end
      checks++;
      if (ws !== (we & ~e_err)) begin
        errors++; $display("FAIL rand_write #%0d got %b want %b", n, ws, we & ~e_err);
      end
      checks++;
      if (rd !== e_rd || er !== e_err) begin
        errors++;
        $display("FAIL rand_rsp #%0d we=%b mm=%b sx=%b a=%h got %h/%b want %h/%b",
                 n, we, mm, sx, a, rd, er, e_rd, e_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) env_mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    test_reset();
    test_store_load();
    test_fairness();
    test_back_to_back();
    test_reset_mid_access();
    test_byte_sext();
    test_align();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
